// File: rtl/imem_loader.sv
// Serialises 32-bit instruction words into big-endian byte writes for the instruction memory.
// Optional IMEM_LOADER_CHECKSUM_EN adds a running mod-2^32 sum of accepted words.
module imem_loader #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           base_addr,
    input  logic [15:0]           load_words,
    input  logic                  word_valid,
    input  logic [31:0]           word_data,
    output logic                  word_ready,
    output logic                  wr_en,
    output logic [31:0]           wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  imem_reg,
    output logic                  busy,
    output logic                  done,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [31:0]           checksum,
`endif
    output logic                  err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

    // A load may not run past the smaller of the declared depth and the addressable range.
    localparam logic [32:0] LP_LIMIT = (DEPTH < (1 << ADDR_WIDTH)) ? 33'(DEPTH) : 33'(1 << ADDR_WIDTH);

    state_t                r_state;
    logic                  r_ready;
    logic                  r_wr_en;
    logic [31:0]           r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_imem;
    logic [15:0]           r_words;
    logic [15:0]           r_cnt;
    logic [1:0]            r_idx;
    logic [31:0]           r_waddr;
    logic [31:0]           r_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]           r_checksum;
`endif

    logic [32:0] w_end;
    logic        w_reject;
    logic        w_accept;
    logic [7:0]  w_byte;

    // End address computed in 33 bits so a base near 2^32 cannot wrap past the check.
    assign w_end    = {1'b0, base_addr} + {15'b0, load_words, 2'b00};
    assign w_reject = (base_addr[1:0] != 2'b00) || (w_end > LP_LIMIT);
    assign w_accept = (r_state == S_LOAD) && word_valid;

    always_comb begin
        w_byte = r_word[31:24];
        case (r_idx)
            2'd1:    w_byte = r_word[23:16];
            2'd2:    w_byte = r_word[15:8];
            2'd3:    w_byte = r_word[7:0];
            default: w_byte = r_word[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_word <= word_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 32'd0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_imem    <= 1'b1;
            r_words   <= 16'd0;
            r_cnt     <= 16'd0;
            r_idx     <= 2'd0;
            r_waddr   <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_checksum <= 32'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt   <= 16'd0;
                        r_idx   <= 2'd0;
                        r_waddr <= base_addr;
                        r_words <= load_words;
                        r_busy  <= 1'b1;
                        r_imem  <= 1'b0;
                        if (w_reject) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_checksum <= 32'd0;
`endif
                            if (load_words == 16'd0) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_ready <= 1'b1;
                                r_state <= S_LOAD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    // Byte 0 goes out on the same edge the word is taken.
                    if (word_valid) begin
                        r_ready   <= 1'b0;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_waddr;
                        r_wr_data <= word_data[31:24];
                        r_idx     <= 2'd1;
                        r_state   <= S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_checksum <= r_checksum + word_data;
`endif
                    end
                end
                S_WRITE: begin
                    if (r_idx != 2'd0) begin
                        r_wr_addr <= r_waddr + 32'(r_idx);
                        r_wr_data <= w_byte;
                        r_idx     <= r_idx + 2'd1;
                    end else begin
                        r_wr_en <= 1'b0;
                        r_waddr <= r_waddr + 32'd4;
                        r_cnt   <= r_cnt + 16'd1;
                        if ((r_cnt + 16'd1) == r_words) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_ready <= 1'b1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_imem  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign word_ready = r_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign imem_reg   = r_imem;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign checksum   = r_checksum;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: expected writes and done events are queued
// by a reference model and drained by an independent monitor.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] load_words;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        imem_reg;
    logic        busy;
    logic        done;
    logic        err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .DEPTH(128)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .load_words (load_words),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .imem_reg   (imem_reg),
        .busy       (busy),
        .done       (done),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .err        (err)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    logic [39:0] exp_wr[$];     // {byte address, byte}
    logic [32:0] exp_done[$];   // {err, checksum}
    logic [31:0] ck_model = 32'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Reference: a load covers bytes base..base+4n-1 and must lie inside the 128-byte memory.
    task automatic model_load(input logic [31:0] base, input logic [15:0] n,
                              input logic [31:0] words[$], output bit rej);
        longint last;
        last = longint'(base) + 4 * longint'(n);
        rej = (base % 4 != 0) || (last > 128);
        if (rej) begin
            exp_done.push_back({1'b1, ck_model});
        end else begin
            ck_model = 32'd0;
            for (int i = 0; i < int'(n); i++) begin
                ck_model = ck_model + words[i];
                for (int b = 0; b < 4; b++) begin
                    exp_wr.push_back({base + 32'(4 * i + b), 8'(words[i] >> (24 - 8 * b))});
                end
            end
            exp_done.push_back({1'b0, ck_model});
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            logic [39:0] ew;
            logic [32:0] ed;
            chk("imem_vs_busy", imem_reg, !busy);
            if (wr_en) begin
                if (exp_wr.size() == 0) fail("unexpected_write");
                else begin
                    ew = exp_wr.pop_front();
                    chk("wr_addr", wr_addr, ew[39:8]);
                    chk("wr_data", wr_data, ew[7:0]);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) fail("unexpected_done");
                else begin
                    ed = exp_done.pop_front();
                    chk("done_err", err, ed[32]);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk("checksum", checksum, ed[31:0]);
`endif
                end
            end
        end
    end

    // vmode: 0 = valid held high, 1 = valid every other cycle, 2 = random valid.
    task automatic do_load(input logic [31:0] base, input logic [15:0] n,
                           input logic [31:0] words_in[$], input int vmode, input bit extra);
        logic [31:0] words[$];
        bit rej;
        int k;
        int phase;
        bit acc;
        words = words_in;
        while (words.size() < int'(n) && words.size() < 64) words.push_back($urandom());
        model_load(base, n, words, rej);
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; load_words = n;
        @(posedge clk); #1;
        start = extra; base_addr = $urandom(); load_words = 16'($urandom());
        chk("busy_c1", busy, 1'b1);
        chk("imem_c1", imem_reg, 1'b0);
        if (rej || n == 16'd0) begin
            chk("done_c1", done, 1'b1);
            chk("err_c1", err, rej);
            @(posedge clk); #1;
            start = 1'b0;
            chk("idle_c2", busy, 1'b0);
        end else begin
            chk("ready_c1", word_ready, 1'b1);
            for (int i = 0; i < int'(n); i++) begin
                word_data = words[i];
                acc = 1'b0;
                k = 0;
                phase = 0;
                while (!acc) begin
                    word_valid = (vmode == 0) || (vmode == 1 && phase % 2 == 1) ||
                                 (vmode == 2 && $urandom_range(0, 1) == 1);
                    phase++;
                    acc = word_valid && word_ready;
                    @(posedge clk); #1;
                    start = 1'b0;
                    k++;
                    if (k > 100) begin
                        $display("FAIL word_accept_timeout at %0t", $time);
                        $fatal(1, "loader never accepted a word");
                    end
                end
                word_valid = 1'b0;
                word_data = $urandom();
                k = 0;
                while (!(word_ready || done) && k < 10) begin
                    @(posedge clk); #1;
                    k++;
                end
                chk("word_gap", k, 4);
            end
            k = 0;
            while (busy && k < 20) begin
                @(posedge clk); #1;
                k++;
            end
            chk("idle_after", busy, 1'b0);
        end
        chk("imem_after", imem_reg, 1'b1);
    endtask

    initial begin
        logic [31:0] wq[$];
        logic [31:0] rb;
        int rn;
        int k;
        rst_n = 1'b0; start = 1'b0; base_addr = 32'd0; load_words = 16'd0;
        word_valid = 1'b0; word_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", word_ready, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_imem", imem_reg, 1'b1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_imem", imem_reg, 1'b1);
        chk("idle_busy", busy, 1'b0);
        mon_en = 1'b1;

        wq.delete(); wq.push_back(32'h00500093);
        do_load(32'd0, 16'd1, wq, 0, 1'b0);
        wq.delete();
        do_load(32'd8, 16'd3, wq, 1, 1'b0);
        do_load(32'd2, 16'd1, wq, 0, 1'b0);
        do_load(32'd124, 16'd2, wq, 0, 1'b0);
        do_load(32'd0, 16'd0, wq, 0, 1'b1);
        do_load(32'd124, 16'd1, wq, 2, 1'b1);
        do_load(32'hFFFF_FFFC, 16'd1, wq, 0, 1'b0);
        do_load(32'd0, 16'hFFFF, wq, 0, 1'b0);
        do_load(32'd0, 16'd32, wq, 2, 1'b0);

        wq.delete(); wq.push_back(32'hFFFF_FFFF); wq.push_back(32'h0000_0002);
        do_load(32'd16, 16'd2, wq, 0, 1'b0);
        wq.delete();

        repeat (14) begin
            rn = $urandom_range(1, 4);
            rb = 32'(4 * $urandom_range(0, 32 - rn));
            case ($urandom_range(0, 5))
                0: rb = rb | 32'($urandom_range(1, 3));
                1: rn = 33 - int'(rb / 4) + $urandom_range(0, 2);
                default: ;
            endcase
            do_load(rb, 16'(rn), wq, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Abandon a load while the second byte is on the write port.
        wq.delete(); wq.push_back(32'h1234_5678);
        model_load(32'd40, 16'd1, wq, rn[0]);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'd40; load_words = 16'd1;
        @(posedge clk); #1;
        start = 1'b0; word_valid = 1'b1; word_data = 32'h1234_5678;
        @(posedge clk); #1;
        word_valid = 1'b0;
        @(posedge clk); #1;
        chk("midwr_en", wr_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", word_ready, 1'b0);
        chk("arst_wr_en", wr_en, 1'b0);
        chk("arst_wr_addr", wr_addr, 32'd0);
        chk("arst_wr_data", wr_data, 8'd0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_err", err, 1'b0);
        chk("arst_imem", imem_reg, 1'b1);
        exp_wr.delete();
        exp_done.delete();
        ck_model = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        wq.delete();
        do_load(32'd100, 16'd2, wq, 2, 1'b1);

        k = 0;
        while ((exp_wr.size() != 0 || exp_done.size() != 0) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time programmer for the byte-addressed instruction memory. Accepts 32-bit instruction words over a valid/ready stream and serialises each into four big-endian byte writes (MSB at the lowest address), matching the fetch-side concatenation `{mem[a], mem[a+1], mem[a+2], mem[a+3]}`. Sits between the host/debug link and the instruction memory write port. Holds the fetch enable (`imem_reg`) low while a load is in progress.

## Interface
- `ADDR_WIDTH`, 7: byte-address width of the target memory.
- `DATA_WIDTH`, 8: memory byte width. Must be 8.
- `DEPTH`, 128: number of bytes in the target memory.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  single-cycle load request; sampled only in IDLE.
- `base_addr`  in  32  first byte address of the load; sampled with `start`.
- `load_words`  in  16  number of 32-bit words to load; sampled with `start`.
- `word_valid`  in  1  source has a word on `word_data`.
- `word_data`  in  32  instruction word.
- `word_ready`  out  1  loader accepts `word_data` this cycle.
- `wr_en`  out  1  memory byte write strobe.
- `wr_addr`  out  32  byte write address.
- `wr_data`  out  DATA_WIDTH  byte write data.
- `imem_reg`  out  1  fetch enable to instruction memory; low while busy.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse at end of every load, including rejected ones.
- `err`  out  1  sticky; set by a rejected load, cleared by the next accepted `start`.

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- IDLE: `start`=1 latches `base_addr`, `load_words`; clears `err`, word counter, byte index.
  - Reject if `base_addr[1:0]` != 0 or `base_addr + 4*load_words > DEPTH`; compute the sum in 33 bits, with no wrap. On reject: set `err`, go to DONE, issue no writes.
  - `load_words` = 0: go to DONE, `err`=0.
  - Otherwise: go to LOAD.
- LOAD: `word_ready`=1. A transfer occurs on `word_valid && word_ready`; the word is latched and the FSM goes to WRITE with byte index 0.
- WRITE: four cycles. `wr_en`=1. `wr_addr` = current word address + index. `wr_data` = `word[31-8*index -: 8]`, so index 0 carries bits [31:24]. After index 3, the word address advances by 4 and the counter increments. If the counter reaches `load_words`, go to DONE; else go to LOAD.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy` = (state != IDLE). `imem_reg` = !`busy`.
- `start` outside IDLE is ignored. `word_valid` outside LOAD is ignored. The source must hold data until ready.

## Timing
- Reset values: state IDLE; `word_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `err`=0, `imem_reg`=1.
- `start` at cycle 0 gives `busy`=1 from cycle 1, and `word_ready`=1 at cycle 1.
- A word accepted at cycle t produces byte writes at t+1 to t+4.
- Next `word_ready` at t+5, or `done` at t+5 after the last word. Peak throughput is 1 word per 5 cycles.
- Rejected or zero-length `start` at cycle 0 gives `done` at cycle 1 and IDLE at cycle 2.
- `rst_n` low mid-load: outputs go to reset values immediately and asynchronously, and the partial load is abandoned. Bytes already written stay written.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - Adds output `checksum` (32 bits), the mod-2^32 sum of all accepted words.
  - Cleared on accepted `start` and on reset.
  - Valid when `done` pulses.
- Undefined: no port, no adder. Behaviour is otherwise identical.

## Test plan
- Reset, then idle: `imem_reg`=1, all other outputs 0. Assert `rst_n` mid-WRITE: outputs return to reset values in the same cycle.
- `start`, `base_addr`=0, `load_words`=1, word 0x00500093 -> writes (0,0x00), (1,0x50), (2,0x00), (3,0x93) on consecutive cycles. `done` pulses after the 4th write. `imem_reg` is 0 throughout, 1 afterwards.
- `base_addr`=8, `load_words`=3, `word_valid` toggled every other cycle -> 12 writes at addresses 8–19, in order. No word is dropped or duplicated.
- `base_addr`=2 -> `err`=1, `done` at cycle 1, zero writes. `base_addr`=124, `load_words`=2 with `DEPTH`=128 -> same rejection.
- `load_words`=0 -> `done` at cycle 1, `err`=0. A second `start` pulsed while busy is ignored: only one `done`.
- With `IMEM_LOADER_CHECKSUM_EN`: words 0xFFFFFFFF and 0x00000002 -> `checksum`=0x00000001 at `done`.
